// File: rtl/reg_file_access_ctrl_if.sv
// Host-side command/response bus of the register-file access controller.
// The host drives commands and accepts responses (master); the controller
// accepts commands and produces responses (slave).
interface reg_file_access_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  CMD_VALID;
    logic                  CMD_READY;
    logic                  CMD_WRITE;
    logic [ADDR_WIDTH-1:0] CMD_ADDR_A;
    logic [ADDR_WIDTH-1:0] CMD_ADDR_B;
    logic [DATA_WIDTH-1:0] CMD_DATA;

    logic                  RSP_VALID;
    logic                  RSP_READY;
    logic                  RSP_WRITE;
    logic [DATA_WIDTH-1:0] RSP_DATA_A;
    logic [DATA_WIDTH-1:0] RSP_DATA_B;

    modport master (
        output CMD_VALID, CMD_WRITE, CMD_ADDR_A, CMD_ADDR_B, CMD_DATA, RSP_READY,
        input  CMD_READY, RSP_VALID, RSP_WRITE, RSP_DATA_A, RSP_DATA_B
    );

    modport slave (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR_A, CMD_ADDR_B, CMD_DATA, RSP_READY,
        output CMD_READY, RSP_VALID, RSP_WRITE, RSP_DATA_A, RSP_DATA_B
    );
endinterface

// File: rtl/reg_file_access_ctrl.sv
// Initiator-side controller for the 32x32 dual-read register file.
// Commands are buffered in a small FIFO, each one is turned into exactly one
// register-file access cycle, and the result (read data or a write echo) is
// returned over a valid/ready response channel. READ and WRITE are decoded
// from a single ACCESS state, so they can never be asserted together.
module reg_file_access_ctrl #(
    parameter int CMD_DEPTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    reg_file_access_ctrl_if.slave bus,
    output logic                  BUSY,
    output logic                  RF_READ,
    output logic                  RF_WRITE,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
    output logic [DATA_WIDTH-1:0] RF_DATA_W,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R2
);

    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = $clog2(CMD_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(CMD_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Command FIFO storage, split per field
    logic                  fifo_write  [CMD_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_a [CMD_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_b [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data   [CMD_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr_a;
    logic [ADDR_WIDTH-1:0] head_addr_b;
    logic [DATA_WIDTH-1:0] head_data;

    state_t                state;
    logic                  cur_write;
    logic [ADDR_WIDTH-1:0] addr_r1_q;
    logic [ADDR_WIDTH-1:0] addr_r2_q;
    logic [ADDR_WIDTH-1:0] addr_w_q;
    logic [DATA_WIDTH-1:0] data_w_q;

    logic                  rsp_valid_q;
    logic                  rsp_write_q;
    logic [DATA_WIDTH-1:0] rsp_data_a_q;
    logic [DATA_WIDTH-1:0] rsp_data_b_q;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);

    // No pass-through: a full FIFO refuses a push even when it pops this cycle.
    assign bus.CMD_READY = !fifo_full && !RST;
    assign push          = bus.CMD_VALID && bus.CMD_READY;

    // The head is consumed when starting from IDLE or when the current
    // response is being accepted with more work already queued.
    assign pop = !RST && !fifo_empty &&
                 ((state == IDLE) || ((state == RESP) && bus.RSP_READY));

    assign head_write  = fifo_write[rd_ptr];
    assign head_addr_a = fifo_addr_a[rd_ptr];
    assign head_addr_b = fifo_addr_b[rd_ptr];
    assign head_data   = fifo_data[rd_ptr];

    // Store an accepted command at the write pointer
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_write[wr_ptr]  <= bus.CMD_WRITE;
            fifo_addr_a[wr_ptr] <= bus.CMD_ADDR_A;
            fifo_addr_b[wr_ptr] <= bus.CMD_ADDR_B;
            fifo_data[wr_ptr]   <= bus.CMD_DATA;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Access sequencer: load a command, run one access cycle, then hold the response
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            cur_write    <= 1'b0;
            addr_r1_q    <= '0;
            addr_r2_q    <= '0;
            addr_w_q     <= '0;
            data_w_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_write_q  <= 1'b0;
            rsp_data_a_q <= '0;
            rsp_data_b_q <= '0;
        end else begin
            if (pop) begin
                cur_write <= head_write;
                if (head_write) begin
                    addr_w_q <= head_addr_a;
                    data_w_q <= head_data;
                end else begin
                    addr_r1_q <= head_addr_a;
                    addr_r2_q <= head_addr_b;
                end
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= ACCESS;
                    end
                end

                ACCESS: begin
                    rsp_valid_q <= 1'b1;
                    rsp_write_q <= cur_write;
                    if (cur_write) begin
                        rsp_data_a_q <= data_w_q;
                        rsp_data_b_q <= '0;
                    end else begin
                        rsp_data_a_q <= RF_DATA_R1;
                        rsp_data_b_q <= RF_DATA_R2;
                    end
                    state <= RESP;
                end

                RESP: begin
                    if (bus.RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        state       <= pop ? ACCESS : IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes exist only in ACCESS and are gated by reset so no write commits at a reset edge.
    assign RF_READ  = (state == ACCESS) && !cur_write && !RST;
    assign RF_WRITE = (state == ACCESS) &&  cur_write && !RST;

    assign RF_ADDR_R1 = addr_r1_q;
    assign RF_ADDR_R2 = addr_r2_q;
    assign RF_ADDR_W  = addr_w_q;
    assign RF_DATA_W  = data_w_q;

    assign bus.RSP_VALID  = rsp_valid_q;
    assign bus.RSP_WRITE  = rsp_write_q;
    assign bus.RSP_DATA_A = rsp_data_a_q;
    assign bus.RSP_DATA_B = rsp_data_b_q;

    assign BUSY = !fifo_empty || (state != IDLE);

endmodule

// File: doc/reg_file_access_ctrl.md
Name: reg_file_access_ctrl

Overview:
Initiator-side controller for the 32x32 dual-read register file. It accepts buffered read-pair and write commands from a host over a valid/ready interface. For each command it drives the register file READ/WRITE/address/data pins for exactly one access cycle. It then returns captured read data, or a write acknowledge, over a valid/ready response channel. It sits between the datapath/control sequencer and the register file, and guarantees READ and WRITE are never asserted together.

Parameters:
CMD_DEPTH, 4, command FIFO depth in entries; power of 2, minimum 2.
DATA_WIDTH, 32, register data width.
ADDR_WIDTH, 5, register address width.

Ports:
CLK  in  1  clock; all state updates on rising edge.
RST  in  1  reset, synchronous, active-high.
CMD_VALID  in  1  host command valid.
CMD_READY  out  1  FIFO can accept a command; equals !full && !RST.
CMD_WRITE  in  1  1 = write, 0 = read pair.
CMD_ADDR_A  in  5  write: destination address; read: address for port 1.
CMD_ADDR_B  in  5  read: address for port 2; ignored on write.
CMD_DATA  in  32  write data; ignored on read.
RSP_VALID  out  1  response valid.
RSP_READY  in  1  host accepts response.
RSP_WRITE  out  1  response belongs to a write command.
RSP_DATA_A  out  32  read: port-1 data; write: data written.
RSP_DATA_B  out  32  read: port-2 data; write: 0.
BUSY  out  1  FIFO non-empty or FSM not in IDLE.
RF_READ  out  1  to register file READ.
RF_WRITE  out  1  to register file WRITE.
RF_ADDR_R1  out  5  to register file ADDR_R1.
RF_ADDR_R2  out  5  to register file ADDR_R2.
RF_ADDR_W  out  5  to register file ADDR_W.
RF_DATA_W  out  32  to register file DATA_W.
RF_DATA_R1  in  32  from register file DATA_R1.
RF_DATA_R2  in  32  from register file DATA_R2.

Behaviour:
- Reset (RST=1 at a rising edge):
  - FIFO emptied; FSM goes to IDLE.
  - RSP_VALID, RSP_WRITE, RSP_DATA_A/B, RF_ADDR_*, RF_DATA_W are cleared to 0.
  - While RST=1: RF_READ=0, RF_WRITE=0 and CMD_READY=0, all combinationally gated, so no register-file write commits at a reset edge.
- Command FIFO:
  - Push on CMD_VALID && CMD_READY.
  - CMD_READY is not-full only; there is no pass-through, so a full FIFO refuses a push even if a pop occurs in the same cycle.
  - Occupancy counter is 0..CMD_DEPTH. Pointers wrap modulo CMD_DEPTH.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the command register, load RF address/data outputs, go to ACCESS.
  - ACCESS (exactly 1 cycle):
    - Read: RF_READ=1, RF_WRITE=0. At the closing edge, capture RF_DATA_R1/R2 into RSP_DATA_A/B, RSP_WRITE=0.
    - Write: RF_WRITE=1, RF_READ=0. The register file loads at the closing edge. RSP_DATA_A=CMD_DATA, RSP_DATA_B=0, RSP_WRITE=1.
    - Set RSP_VALID=1 and go to RESP.
  - RESP: hold RSP_* stable while RSP_READY=0. On RSP_READY=1:
    - FIFO non-empty: pop and go directly to ACCESS.
    - Otherwise: RSP_VALID drops at the edge and the FSM goes to IDLE.
- RF_READ and RF_WRITE are decoded from state and the command register, and are 0 outside ACCESS. RF address/data outputs hold their last value outside ACCESS.
- Latency: command accepted at edge k into an empty, idle controller:
  - ACCESS occupies cycle k+1.
  - RSP_VALID=1 from edge k+2.
- Throughput: one command per 2 cycles with RSP_READY held high.
- Ordering:
  - Strictly in order.
  - A write completes at the edge ending its ACCESS, so a following read of the same address returns the new value.
- Capacity under backpressure: CMD_DEPTH queued plus 1 in RESP.
- Reset mid-operation: any in-flight command and all queued commands are discarded, and no response is issued.

Test Plan:
1. Reset, write r5=0xDEADBEEF, then read (A=5, B=0) -> write rsp RSP_WRITE=1, DATA_A=0xDEADBEEF; read rsp DATA_A=0xDEADBEEF, DATA_B=0x00000000.
2. Idle controller, read accepted at edge k -> RF_READ=1 only in cycle k+1, RSP_VALID rises at edge k+2.
3. RSP_READY=1, 8 back-to-back reads of r0..r7 preloaded with 0x100+i -> responses every 2 cycles in order; RF_READ&&RF_WRITE never 1.
4. RSP_READY=0, CMD_VALID held -> exactly 5 commands accepted, then CMD_READY=0; RSP_* stable; releasing RSP_READY drains all 5 in order.
5. Write r9=0x0000CAFE, immediately read (9,9) -> DATA_A=DATA_B=0x0000CAFE.
6. Write r7=0x1234 (r7 previously 0x55) with RST=1 during its ACCESS cycle -> RF_WRITE=0 that cycle; no response; later read of r7 returns 0x55.
